// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resetting to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Mid-bit sampling from a single down-counting baud counter.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_frame_error,
    output logic       rx_parity_error
);

    localparam int                CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t              state;
    logic [CNT_W-1:0]            baud_cnt;
    logic [2:0]                  bit_idx;
    logic [UART_DATA_BITS-1:0]   shift_reg;
    logic                        rx_s;

    sync_2ff #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
`else
    assign rx_parity_error = 1'b0;
`endif

    // Every sampling state counts down to zero, samples, then reloads exactly one bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            rx_byte        <= 8'h00;
            rx_byte_valid  <= 1'b0;
            rx_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_error <= 1'b0;
            parity_bad      <= 1'b0;
`endif
        end else begin
            rx_byte_valid  <= 1'b0;
            rx_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_RELOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= BIT_RELOAD;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end else begin
                        shift_reg[bit_idx] <= rx_s;
                        baud_cnt           <= BIT_RELOAD;
                        bit_idx            <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end else begin
                        parity_bad <= (rx_s != ^shift_reg);
                        baud_cnt   <= BIT_RELOAD;
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_bad) begin
                            rx_parity_error <= 1'b1;
                        end else begin
                            rx_byte       <= shift_reg;
                            rx_byte_valid <= 1'b1;
                        end
`else
                        rx_byte       <= shift_reg;
                        rx_byte_valid <= 1'b1;
`endif
                        state <= IDLE;
                    end else begin
                        // A low stop bit reports only the framing error, even if parity was also bad.
                        rx_frame_error <= 1'b1;
                        state          <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 16 clocks per bit; covers parity when UART_RX_PARITY_EN is defined.
module tb_uart_rx_framer;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_frame_error;
    logic       rx_parity_error;

    int check_count     = 0;
    int error_count     = 0;
    int valid_count     = 0;
    int frame_err_count = 0;
    int parity_err_count = 0;
    int overlap_count   = 0;
    int consec_count    = 0;
    bit prev_pulse      = 1'b0;
    logic [7:0] byte_q[$];

    uart_rx_framer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_serial       (rx_serial),
        .rx_byte         (rx_byte),
        .rx_byte_valid   (rx_byte_valid),
        .rx_frame_error  (rx_frame_error),
        .rx_parity_error (rx_parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping on the falling edge, away from the registers' update edge.
    always @(negedge clk) begin
        int n;
        n = int'(rx_byte_valid) + int'(rx_frame_error) + int'(rx_parity_error);
        if (n > 1) overlap_count++;
        if (n > 0 && prev_pulse) consec_count++;
        prev_pulse = (n > 0);
        if (rx_byte_valid) begin
            valid_count++;
            byte_q.push_back(rx_byte);
        end
        if (rx_frame_error) frame_err_count++;
        if (rx_parity_error) parity_err_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(posedge clk);
    endtask

    // Sends one frame; the parity bit is only put on the line in the 8E1 build.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) drive_bit(1'b1);
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int cycles);
        rx_serial = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int v0, f0, p0;
        rst       = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rx_byte", 32'(rx_byte), 32'h00);
        checkOutput("reset_valid", 32'(rx_byte_valid), 32'h0);
        checkOutput("reset_frame_err", 32'(rx_frame_error), 32'h0);
        checkOutput("reset_parity_err", 32'(rx_parity_error), 32'h0);
        rst = 1'b0;
        idle(10);

        // Single good frame
        v0 = valid_count; f0 = frame_err_count; p0 = parity_err_count;
        applyStimulus(8'h13, ^8'h13, 1'b1);
        idle(20);
        checkOutput("f13_valid_pulses", 32'(valid_count - v0), 32'd1);
        checkOutput("f13_rx_byte", 32'(rx_byte), 32'h13);
        checkOutput("f13_frame_err", 32'(frame_err_count - f0), 32'd0);
        checkOutput("f13_parity_err", 32'(parity_err_count - p0), 32'd0);

        // Short low glitch must be rejected at the mid-start check
        v0 = valid_count; f0 = frame_err_count;
        rx_serial = 1'b0;
        repeat (6) @(posedge clk);
        idle(40);
        checkOutput("glitch_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("glitch_frame_err", 32'(frame_err_count - f0), 32'd0);
        checkOutput("glitch_rx_byte", 32'(rx_byte), 32'h13);

        // Low stop bit, line held low, then a good frame
        v0 = valid_count; f0 = frame_err_count; p0 = parity_err_count;
        applyStimulus(8'hA5, ^8'hA5, 1'b0);
        rx_serial = 1'b0;
        repeat (100) @(posedge clk);
        idle(20);
        checkOutput("break_frame_err", 32'(frame_err_count - f0), 32'd1);
        checkOutput("break_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("break_parity_err", 32'(parity_err_count - p0), 32'd0);
        checkOutput("break_rx_byte_held", 32'(rx_byte), 32'h13);
        applyStimulus(8'h3C, ^8'h3C, 1'b1);
        idle(20);
        checkOutput("after_break_valid", 32'(valid_count - v0), 32'd1);
        checkOutput("after_break_rx_byte", 32'(rx_byte), 32'h3C);

        // Four back-to-back frames with no idle gap
        v0 = valid_count;
        for (int k = 0; k < 4; k++) applyStimulus(8'hFF, ^8'hFF, 1'b1);
        idle(20);
        checkOutput("b2b_valid_pulses", 32'(valid_count - v0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (byte_q.size() >= 4 - k)
                checkOutput($sformatf("b2b_byte%0d", k), 32'(byte_q[byte_q.size() - 4 + k]), 32'hFF);
            else
                checkOutput($sformatf("b2b_byte%0d_missing", k), 32'(byte_q.size()), 32'(4 - k));
        end

        // Reset in the middle of bit 4 of 8'h55 aborts the frame
        v0 = valid_count; f0 = frame_err_count; p0 = parity_err_count;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
        rx_serial = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_rx_byte_reset", 32'(rx_byte), 32'h00);
        rst = 1'b0;
        idle(200);
        checkOutput("abort_no_pulses", 32'(valid_count - v0 + frame_err_count - f0 + parity_err_count - p0), 32'd0);
        applyStimulus(8'h0F, ^8'h0F, 1'b1);
        idle(20);
        checkOutput("abort_then_valid", 32'(valid_count - v0), 32'd1);
        checkOutput("abort_then_rx_byte", 32'(rx_byte), 32'h0F);

`ifdef UART_RX_PARITY_EN
        // 8'h07 has three ones, so even parity needs a 1 on the line
        v0 = valid_count; f0 = frame_err_count; p0 = parity_err_count;
        applyStimulus(8'h07, 1'b0, 1'b1);
        idle(20);
        checkOutput("par_bad_parity_err", 32'(parity_err_count - p0), 32'd1);
        checkOutput("par_bad_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("par_bad_frame_err", 32'(frame_err_count - f0), 32'd0);
        checkOutput("par_bad_rx_byte_held", 32'(rx_byte), 32'h0F);
        applyStimulus(8'h07, 1'b1, 1'b1);
        idle(20);
        checkOutput("par_good_valid", 32'(valid_count - v0), 32'd1);
        checkOutput("par_good_rx_byte", 32'(rx_byte), 32'h07);
        checkOutput("par_good_parity_err", 32'(parity_err_count - p0), 32'd1);
`endif

        checkOutput("pulse_overlap", 32'(overlap_count), 32'd0);
        checkOutput("pulse_consecutive", 32'(consec_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
